fft64: RTL and testbench

64-point complex radix-2 decimation-in-time FFT engine with a one-shot start interface. It captures 64 signed 16-bit complex samples in parallel on a start pulse, runs six butterfly stages on an internal register array, and presents all 64 complex bins in parallel on holding output registers. It sits between a sample-buffer/front-end and downstream spectral processing, and is controlled by a simple start/done handshake.

---
 rtl/fft64.sv | 207 ++++++++++++++++++++
 tb/tb_fft64.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft64.sv
// ============================================================================
// fft64 -- 64-point complex radix-2 decimation-in-time FFT, one-shot.
//
// A rising edge on start while idle captures all 64 complex samples into a
// working register array in bit-reversed order. Six butterfly stages then run
// in place, four butterflies per clock and eight clocks per stage. Each stage
// halves its result, so the overall scale is 1/64. The finished array is then
// copied to the holding output registers, and done pulses for one cycle.
// Latency is 50 clocks from the accepting edge to valid outputs.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any transform and clears
//              the outputs
//   start      launch request; only a rising edge seen while idle is accepted
//   input_Re   x[n] real parts, n = 0..63, signed Q1.15, element [n]
//   input_Im   x[n] imaginary parts, n = 0..63, signed Q1.15, element [n]
//   output_Re  X[k] real parts, k = 0..63, signed Q1.15, registered
//   output_Im  X[k] imaginary parts, k = 0..63, signed Q1.15, registered
//   done       one-cycle pulse in the cycle a new result appears
// ============================================================================
module fft64 (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0][15:0] input_Re,
    input  logic [63:0][15:0] input_Im,
    output logic [63:0][15:0] output_Re,
    output logic [63:0][15:0] output_Im,
    output logic             done
);
    // The working array is loaded on the accepting edge itself, so no separate
    // load cycle exists between IDLE and the first stage cycle.
    typedef enum logic [1:0] {IDLE, STAGE, OUT} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_start_d;
    logic [2:0]         r_stage;
    logic [2:0]         r_group;
    logic signed [15:0] r_work_re [64];
    logic signed [15:0] r_work_im [64];

    logic               w_launch;
    logic               w_last;
    logic [5:0]         w_mask;
    logic [5:0]         w_j  [4];
    logic [5:0]         w_a  [4];
    logic [5:0]         w_b  [4];
    logic [4:0]         w_t  [4];
    logic signed [15:0] w_c  [4];
    logic signed [15:0] w_s  [4];
    logic signed [15:0] w_ar [4];
    logic signed [15:0] w_ai [4];
    logic signed [15:0] w_br [4];
    logic signed [15:0] w_bi [4];
    logic signed [16:0] w_p_re [4];
    logic signed [16:0] w_p_im [4];
    logic signed [15:0] w_na_re [4];
    logic signed [15:0] w_na_im [4];
    logic signed [15:0] w_nb_re [4];
    logic signed [15:0] w_nb_im [4];

    function automatic logic [5:0] bitrev6(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

    // cos(2*pi*i/64) in Q1.15 for the first quadrant, i = 0..16; the other
    // quadrants are folded onto this table by tw_cos/tw_sin.
    function automatic logic signed [15:0] cos_q(input logic [4:0] i);
        case (i)
            5'd0:    return 16'sd32767;
            5'd1:    return 16'sd32610;
            5'd2:    return 16'sd32138;
            5'd3:    return 16'sd31357;
            5'd4:    return 16'sd30274;
            5'd5:    return 16'sd28899;
            5'd6:    return 16'sd27246;
            5'd7:    return 16'sd25330;
            5'd8:    return 16'sd23170;
            5'd9:    return 16'sd20788;
            5'd10:   return 16'sd18205;
            5'd11:   return 16'sd15447;
            5'd12:   return 16'sd12540;
            5'd13:   return 16'sd9512;
            5'd14:   return 16'sd6393;
            5'd15:   return 16'sd3212;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] tw_cos(input logic [4:0] t);
        if (t <= 5'd16) return cos_q(t);
        else            return -cos_q(5'(6'd32 - {1'b0, t}));
    endfunction

    function automatic logic signed [15:0] tw_sin(input logic [4:0] t);
        if (t <= 5'd16) return cos_q(5'd16 - t);
        else            return cos_q(t - 5'd16);
    endfunction

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so
        // no path can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_last      = (r_stage == 3'd5) && (r_group == 3'd7);
        case (r_state)
            IDLE: begin
                if (start && !r_start_d) begin
                    w_launch    = 1'b1;
                    w_state_nxt = STAGE;
                end
            end
            STAGE:   if (w_last) w_state_nxt = OUT;
            OUT:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Butterfly addressing and arithmetic. Butterfly j = {group, k} of stage s
    // pairs a (j with a zero inserted at bit s) and b = a + 2^s. The four
    // butterflies of one cycle therefore never touch the same entry.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mask = (6'd1 << r_stage) - 6'd1;
        for (int k = 0; k < 4; k++) begin
            w_j[k]  = {1'b0, r_group, 2'(k)};
            w_a[k]  = ((w_j[k] & ~w_mask) << 1) | (w_j[k] & w_mask);
            w_b[k]  = w_a[k] | (6'd1 << r_stage);
            w_t[k]  = 5'((w_j[k] & w_mask) << (3'd5 - r_stage));
            w_c[k]  = tw_cos(w_t[k]);
            w_s[k]  = tw_sin(w_t[k]);
            w_ar[k] = r_work_re[w_a[k]];
            w_ai[k] = r_work_im[w_a[k]];
            w_br[k] = r_work_re[w_b[k]];
            w_bi[k] = r_work_im[w_b[k]];
            // p = b * (c - j*s), rounded to nearest and kept at 17 bits; the
            // 32-bit sum cannot overflow because |c| + |s| < 1.42 in Q1.15.
            w_p_re[k] = 17'((32'(w_br[k]) * 32'(w_c[k]) + 32'(w_bi[k]) * 32'(w_s[k])
                             + 32'sd16384) >>> 15);
            w_p_im[k] = 17'((32'(w_bi[k]) * 32'(w_c[k]) - 32'(w_br[k]) * 32'(w_s[k])
                             + 32'sd16384) >>> 15);
            // Per-stage halving: floor of (a +/- p)/2, truncated to 16 bits.
            w_na_re[k] = 16'((18'(w_ar[k]) + 18'(w_p_re[k])) >>> 1);
            w_na_im[k] = 16'((18'(w_ai[k]) + 18'(w_p_im[k])) >>> 1);
            w_nb_re[k] = 16'((18'(w_ar[k]) - 18'(w_p_re[k])) >>> 1);
            w_nb_im[k] = 16'((18'(w_ai[k]) - 18'(w_p_im[k])) >>> 1);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every butterfly in a
        // cycle reads the array as it stood before this edge.
        if (rst) begin
            r_start_d <= 1'b0;
            r_stage   <= 3'd0;
            r_group   <= 3'd0;
            done      <= 1'b0;
            output_Re <= '0;
            output_Im <= '0;
            // NOTE: the working array is deliberately reset; it is built from
            // flops, not a RAM macro, so clearing it costs only reset fan-out.
            for (int i = 0; i < 64; i++) begin
                r_work_re[i] <= '0;
                r_work_im[i] <= '0;
            end
        end else begin
            r_start_d <= start;
            done      <= (r_state == OUT);
            if (w_launch) begin
                r_stage <= 3'd0;
                r_group <= 3'd0;
                for (int n = 0; n < 64; n++) begin
                    r_work_re[bitrev6(6'(n))] <= input_Re[n];
                    r_work_im[bitrev6(6'(n))] <= input_Im[n];
                end
            end else if (r_state == STAGE) begin
                r_group <= r_group + 3'd1;
                if (r_group == 3'd7) r_stage <= r_stage + 3'd1;
                for (int k = 0; k < 4; k++) begin
                    r_work_re[w_a[k]] <= w_na_re[k];
                    r_work_im[w_a[k]] <= w_na_im[k];
                    r_work_re[w_b[k]] <= w_nb_re[k];
                    r_work_im[w_b[k]] <= w_nb_im[k];
                end
            end
            if (r_state == OUT) begin
                for (int i = 0; i < 64; i++) begin
                    output_Re[i] <= r_work_re[i];
                    output_Im[i] <= r_work_im[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_fft64.sv
// ============================================================================
// tb_fft64 -- self-checking bench for fft64.
// Expected spectra come from closed-form DFT results of simple inputs
// (impulse, DC, tones); they are queued at launch and popped on done.
// ============================================================================
`timescale 1ns/1ps
module tb_fft64;
    localparam real PI = 3.14159265358979;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [63:0][15:0] in_re, in_im;
    logic [63:0][15:0] out_re, out_im;
    logic              done;

    always #5 clk = ~clk;

    fft64 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .input_Re  (in_re),
        .input_Im  (in_im),
        .output_Re (out_re),
        .output_Im (out_im),
        .done      (done)
    );

    typedef struct {
        logic [63:0][15:0] re;
        logic [63:0][15:0] im;
        int                tol;
    } exp_t;

    exp_t              sb_q[$];
    exp_t              e;
    exp_t              last_e;
    logic [63:0][15:0] mid_re, mid_im;
    int                total = 0;
    int                bad   = 0;
    int                lat;
    int                extra;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(0.5 - v);
    endfunction

    function automatic int absdiff(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return (d < 0) ? -d : d;
    endfunction

    // Called at a negedge with start already raised. Returns the number of
    // negedges until done is seen (50 for a correct design) or -1 if it never
    // arrives within 80 cycles. poke_kind: 1 = extra start pulse with new
    // inputs, 2 = one-cycle reset, 3 = snapshot of the outputs.
    task automatic wait_done(input int hold, input int poke_c, input int poke_kind,
                             output int cycles);
        cycles = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == hold) start = 1'b0;
            if (c == poke_c) begin
                case (poke_kind)
                    1: begin
                        start = 1'b1;
                        in_re = '0;
                        in_im = '0;
                        in_re[3] = 16'h7fff;
                    end
                    2: rst = 1'b1;
                    3: begin
                        mid_re = out_re;
                        mid_im = out_im;
                    end
                    default: ;
                endcase
            end
            if (c == poke_c + 1) begin
                if (poke_kind == 1) start = 1'b0;
                if (poke_kind == 2) rst = 1'b0;
            end
            if (done === 1'b1) begin
                cycles = c;
                break;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++;
        if (out_re !== '0) begin bad++; $display("FAIL reset_out_re: bin0 got %h want 0000", out_re[0]); end
        total++;
        if (out_im !== '0) begin bad++; $display("FAIL reset_out_im: bin0 got %h want 0000", out_im[0]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_impulse;
        in_re = '0; in_im = '0; in_re[0] = 16'h4000;
        for (int k = 0; k < 64; k++) begin e.re[k] = 16'h0100; e.im[k] = 16'h0000; end
        e.tol = 0;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 0, 0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL impulse_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        for (int k = 0; k < 64; k++) begin
            total++;
            if (absdiff(out_re[k], e.re[k]) > e.tol || absdiff(out_im[k], e.im[k]) > e.tol) begin
                bad++;
                $display("FAIL impulse bin %0d: got (%h,%h) want (%h,%h) +/-%0d",
                         k, out_re[k], out_im[k], e.re[k], e.im[k], e.tol);
            end
        end
        last_e = e;
        count_done(60, extra);
        total++;
        if (extra !== 0) begin bad++; $display("FAIL impulse_single_done: extra pulses %0d want 0", extra); end
    endtask

    task automatic test_hold;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            total++;
            if (out_re !== last_e.re || out_im !== last_e.im || done !== 1'b0) begin
                bad++;
                $display("FAIL hold cycle %0d: done=%b bin0=(%h,%h) want done=0 bin0=(%h,%h)",
                         c, done, out_re[0], out_im[0], last_e.re[0], last_e.im[0]);
            end
        end
    endtask

    task automatic test_dc;
        for (int n = 0; n < 64; n++) begin in_re[n] = 16'h4000; in_im[n] = 16'h0000; end
        e.re = '0; e.im = '0; e.re[0] = 16'h4000; e.tol = 1;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 0, 0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL dc_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        for (int k = 0; k < 64; k++) begin
            total++;
            if (absdiff(out_re[k], e.re[k]) > e.tol || absdiff(out_im[k], e.im[k]) > e.tol) begin
                bad++;
                $display("FAIL dc bin %0d: got (%h,%h) want (%h,%h) +/-%0d",
                         k, out_re[k], out_im[k], e.re[k], e.im[k], e.tol);
            end
        end
        last_e = e;
    endtask

    task automatic test_tone;
        for (int n = 0; n < 64; n++) begin
            in_re[n] = 16'(rnd(16384.0 * $cos(2.0 * PI * n / 64.0)));
            in_im[n] = 16'h0000;
        end
        e.re = '0; e.im = '0; e.re[1] = 16'h2000; e.re[63] = 16'h2000; e.tol = 2;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 0, 0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL tone_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        for (int k = 0; k < 64; k++) begin
            total++;
            if (absdiff(out_re[k], e.re[k]) > e.tol || absdiff(out_im[k], e.im[k]) > e.tol) begin
                bad++;
                $display("FAIL tone bin %0d: got (%h,%h) want (%h,%h) +/-%0d",
                         k, out_re[k], out_im[k], e.re[k], e.im[k], e.tol);
            end
        end
        last_e = e;
    endtask

    task automatic test_complex_tone;
        for (int n = 0; n < 64; n++) begin
            in_re[n] = 16'(rnd(16384.0 * $cos(2.0 * PI * 5.0 * n / 64.0)));
            in_im[n] = 16'(rnd(16384.0 * $sin(2.0 * PI * 5.0 * n / 64.0)));
        end
        e.re = '0; e.im = '0; e.re[5] = 16'h4000; e.tol = 3;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 0, 0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL ctone_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        for (int k = 0; k < 64; k++) begin
            total++;
            if (absdiff(out_re[k], e.re[k]) > e.tol || absdiff(out_im[k], e.im[k]) > e.tol) begin
                bad++;
                $display("FAIL ctone bin %0d: got (%h,%h) want (%h,%h) +/-%0d",
                         k, out_re[k], out_im[k], e.re[k], e.im[k], e.tol);
            end
        end
        last_e = e;
    endtask

    task automatic test_start_hold;
        in_re = '0; in_im = '0; in_re[0] = 16'h2000;
        for (int k = 0; k < 64; k++) begin e.re[k] = 16'h0080; e.im[k] = 16'h0000; end
        e.tol = 0;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(2, 0, 0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL hold2_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        total++;
        if (out_re !== e.re || out_im !== e.im) begin
            bad++;
            $display("FAIL hold2_result: bin0 got (%h,%h) want (%h,%h)",
                     out_re[0], out_im[0], e.re[0], e.im[0]);
        end
        last_e = e;
        count_done(60, extra);
        total++;
        if (extra !== 0) begin bad++; $display("FAIL hold2_single_launch: extra pulses %0d want 0", extra); end
    endtask

    task automatic test_ignore_midrun;
        for (int n = 0; n < 64; n++) begin in_re[n] = 16'h4000; in_im[n] = 16'h0000; end
        e.re = '0; e.im = '0; e.re[0] = 16'h4000; e.tol = 1;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 10, 1, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL ignore_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        for (int k = 0; k < 64; k++) begin
            total++;
            if (absdiff(out_re[k], e.re[k]) > e.tol || absdiff(out_im[k], e.im[k]) > e.tol) begin
                bad++;
                $display("FAIL ignore bin %0d: got (%h,%h) want (%h,%h) +/-%0d",
                         k, out_re[k], out_im[k], e.re[k], e.im[k], e.tol);
            end
        end
        last_e = e;
        count_done(60, extra);
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ignore_no_relaunch: extra pulses %0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        exp_t prev_e;
        in_re = '0; in_im = '0; in_re[0] = 16'h4000;
        for (int k = 0; k < 64; k++) begin e.re[k] = 16'h0100; e.im[k] = 16'h0000; end
        e.tol = 0;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 0, 0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL b2b_first_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        total++;
        if (out_re !== e.re || out_im !== e.im) begin
            bad++;
            $display("FAIL b2b_first_result: bin0 got (%h,%h) want (%h,%h)",
                     out_re[0], out_im[0], e.re[0], e.im[0]);
        end
        prev_e = e;
        // Relaunch on the very next edge after the first result appears.
        for (int n = 0; n < 64; n++) begin in_re[n] = 16'h4000; in_im[n] = 16'h0000; end
        e.re = '0; e.im = '0; e.re[0] = 16'h4000; e.tol = 1;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 25, 3, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL b2b_second_latency: got %0d want 50", lat); end
        total++;
        if (mid_re !== prev_e.re || mid_im !== prev_e.im) begin
            bad++;
            $display("FAIL b2b_hold_during_run: bin0 got (%h,%h) want (%h,%h)",
                     mid_re[0], mid_im[0], prev_e.re[0], prev_e.im[0]);
        end
        e = sb_q.pop_front();
        for (int k = 0; k < 64; k++) begin
            total++;
            if (absdiff(out_re[k], e.re[k]) > e.tol || absdiff(out_im[k], e.im[k]) > e.tol) begin
                bad++;
                $display("FAIL b2b_second bin %0d: got (%h,%h) want (%h,%h) +/-%0d",
                         k, out_re[k], out_im[k], e.re[k], e.im[k], e.tol);
            end
        end
        last_e = e;
    endtask

    task automatic test_reset_midrun;
        for (int n = 0; n < 64; n++) begin
            in_re[n] = 16'(rnd(16384.0 * $cos(2.0 * PI * n / 64.0)));
            in_im[n] = 16'h0000;
        end
        start = 1'b1;
        wait_done(1, 20, 2, lat);
        total++;
        if (lat !== -1) begin bad++; $display("FAIL abort_no_done: done seen at %0d want none", lat); end
        total++;
        if (out_re !== '0 || out_im !== '0) begin
            bad++;
            $display("FAIL abort_outputs_zero: bin0 got (%h,%h) want (0000,0000)", out_re[0], out_im[0]);
        end
        in_re = '0; in_im = '0; in_re[0] = 16'h4000;
        for (int k = 0; k < 64; k++) begin e.re[k] = 16'h0100; e.im[k] = 16'h0000; end
        e.tol = 0;
        sb_q.push_back(e);
        start = 1'b1;
        wait_done(1, 0, 0, lat);
        total++;
        if (lat !== 50) begin bad++; $display("FAIL post_reset_latency: got %0d want 50", lat); end
        e = sb_q.pop_front();
        for (int k = 0; k < 64; k++) begin
            total++;
            if (out_re[k] !== e.re[k] || out_im[k] !== e.im[k]) begin
                bad++;
                $display("FAIL post_reset bin %0d: got (%h,%h) want (%h,%h)",
                         k, out_re[k], out_im[k], e.re[k], e.im[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_re = '0; in_im = '0;
        mid_re = '0; mid_im = '0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_hold();
        test_dc();
        test_tone();
        test_complex_tone();
        test_start_hold();
        test_ignore_midrun();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
